// File: rtl/mips16_pkg.sv
// Shared constants and types for the mips16 fetch front end.
package mips16_pkg;

   localparam int PC_W    = 13;
   localparam int INSTR_W = 16;

   localparam logic [PC_W-1:0] RESET_PC = 13'h0000;

   // Fetch sequencer states. The 2-bit encoding is visible on the debug port.
   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      REQ     = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, issues one fetch at a time to instruction
// memory, and presents the returned word to decode until it is consumed.
//
// Handshakes:
//   memory side : imem_req is held with a stable imem_addr until a cycle in
//                 which imem_ready is high; that cycle's imem_rdata is the
//                 response. imem_req is low whenever no fetch is in flight.
//   decode side : instr is valid while instr_valid is high. It is consumed on
//                 a rising edge where instr_valid && !stall && !flush; it is
//                 held unchanged while stall is high. flush overrides both and
//                 discards both the held word and any in-flight fetch.
module pc_fetch_unit #(
   parameter int                PC_W     = mips16_pkg::PC_W,
   parameter int                INSTR_W  = mips16_pkg::INSTR_W,
   parameter logic [PC_W-1:0]   RESET_PC = mips16_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    pc_loopback,
   input  logic               flush,
   input  logic               stall,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_plus1,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [1:0]         dbg_state
);

   import mips16_pkg::*;

   fetch_state_t         r_state;
   fetch_state_t         w_state_nxt;
   logic [PC_W-1:0]      r_pc;
   logic [PC_W-1:0]      w_pc_nxt;
   logic [PC_W-1:0]      r_addr;
   logic [PC_W-1:0]      w_addr_nxt;
   logic [INSTR_W-1:0]   r_instr;
   logic [INSTR_W-1:0]   w_instr_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic                 w_req;

   // State, PC, fetch address and instruction registers; async reset to BOOT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_addr  <= w_addr_nxt;
         r_instr <= w_instr_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Next-state and register-update logic; priority is flush > consume > stall.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_addr_nxt  = r_addr;
      w_instr_nxt = r_instr;
      w_valid_nxt = r_valid;
      w_req       = 1'b0;

      case (r_state)
         BOOT: begin
            // First fetch goes out next cycle; a flush here simply retargets it.
            w_state_nxt = REQ;
            if (flush) begin
               w_pc_nxt   = pc_loopback;
               w_addr_nxt = pc_loopback;
            end else begin
               w_addr_nxt = r_pc;
            end
         end

         REQ: begin
            w_req = 1'b1;
            if (flush) begin
               w_pc_nxt = pc_loopback;
               if (imem_ready) begin
                  // Response arrives with the flush: drop it, refetch at once.
                  w_addr_nxt = pc_loopback;
               end else begin
                  // Old request must still be completed on its original address.
                  w_state_nxt = DISCARD;
               end
            end else if (imem_ready) begin
               w_instr_nxt = imem_rdata;
               w_valid_nxt = 1'b1;
               w_state_nxt = HOLD;
            end
         end

         DISCARD: begin
            // Keep the stale request alive until memory answers, then drop it.
            w_req = 1'b1;
            if (flush) begin
               w_pc_nxt = pc_loopback;
            end
            if (imem_ready) begin
               w_addr_nxt  = w_pc_nxt;
               w_state_nxt = REQ;
            end
         end

         HOLD: begin
            // Flush or consume both release the word and load the next PC.
            if (flush || !stall) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = pc_loopback;
               w_addr_nxt  = pc_loopback;
               w_state_nxt = REQ;
            end
         end

         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   // Outputs are direct register views plus the sequential-flow increment.
   always_comb begin
      imem_req    = w_req;
      imem_addr   = r_addr;
      pc          = r_pc;
      pc_plus1    = r_pc + PC_W'(1);
      instr       = r_instr;
      instr_valid = r_valid;
      dbg_state   = r_state;
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scenario tasks plus a delivery
// scoreboard that pairs each expected {pc, instr} with the next new
// instr_valid assertion.
module tb_pc_fetch_unit;

   import mips16_pkg::*;

   logic               clk;
   logic               rst_n;
   logic [PC_W-1:0]    pc_loopback;
   logic               flush;
   logic               stall;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_plus1;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [1:0]         dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [PC_W+INSTR_W-1:0] exp_q[$];
   logic [PC_W+INSTR_W-1:0] exp_e;
   logic                    prev_valid = 1'b0;

   bit auto_lb  = 1'b0;
   bit auto_mem = 1'b0;

   pc_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_loopback (pc_loopback),
      .flush       (flush),
      .stall       (stall),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .instr       (instr),
      .instr_valid (instr_valid),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required finish");
      $fatal(1);
   end

   // memory contents: each address returns a distinct word
   function automatic logic [INSTR_W-1:0] word_of(input logic [PC_W-1:0] a);
      return {3'b101, a};
   endfunction

   // driver: advance one cycle, then refresh the modelled upstream mux and memory
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_lb)  pc_loopback = pc_plus1;
      if (auto_mem) imem_rdata  = word_of(imem_addr);
   endtask

   // scoreboard: every rising instr_valid must match the next expected delivery
   always @(negedge clk) begin
      if (rst_n && instr_valid && !prev_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", pc, instr);
         end else begin
            exp_e = exp_q.pop_front();
            if ({pc, instr} !== exp_e) begin
               failures++;
               $display("FAIL sb_delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                        pc, instr, exp_e[PC_W+INSTR_W-1:INSTR_W], exp_e[INSTR_W-1:0]);
            end
         end
      end
      prev_valid <= instr_valid;
   end

   task automatic test_reset();
      repeat (2) tick();
      checks++; if (pc !== 13'h0000) begin failures++; $display("FAIL rst_pc: got %h, required 0000", pc); end
      checks++; if (imem_addr !== 13'h0000) begin failures++; $display("FAIL rst_addr: got %h, required 0000", imem_addr); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, required 0", imem_req); end
      checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL rst_instr: got %h, required 0000", instr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
      checks++; if (dbg_state !== BOOT) begin failures++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, BOOT); end
   endtask

   task automatic test_sequential();
      imem_ready  = 1'b1;
      auto_lb     = 1'b1;
      auto_mem    = 1'b1;
      pc_loopback = 13'h0001;
      imem_rdata  = word_of(13'h0000);
      rst_n       = 1'b1;
      tick();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL seq_first_valid: got %b, required 0", instr_valid); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dbg_state !== REQ) begin failures++; $display("FAIL seq_state_req: got %0d, required %0d", dbg_state, REQ); end
         checks++; if (pc !== PC_W'(i)) begin failures++; $display("FAIL seq_pc: got %h, required %h", pc, PC_W'(i)); end
         checks++; if (imem_addr !== PC_W'(i)) begin failures++; $display("FAIL seq_addr: got %h, required %h", imem_addr, PC_W'(i)); end
         checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req: got %b, required 1", imem_req); end
         exp_q.push_back({PC_W'(i), word_of(PC_W'(i))});
         tick();
         checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid: got %b, required 1", instr_valid); end
         checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_hold_req: got %b, required 0", imem_req); end
         tick();
      end
   endtask

   task automatic test_stall();
      // entering at REQ with pc=4
      auto_mem   = 1'b0;
      imem_rdata = 16'h1234;
      exp_q.push_back({13'h0004, 16'h1234});
      tick();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (instr !== 16'h1234) begin failures++; $display("FAIL stall_instr: got %h, required 1234", instr); end
         checks++; if (pc !== 13'h0004) begin failures++; $display("FAIL stall_pc: got %h, required 0004", pc); end
         checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b, required 1", instr_valid); end
         checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b, required 0", imem_req); end
         checks++; if (dbg_state !== HOLD) begin failures++; $display("FAIL stall_state: got %0d, required %0d", dbg_state, HOLD); end
      end
      stall    = 1'b0;
      auto_mem = 1'b1;
      tick();
      checks++; if (pc !== 13'h0005) begin failures++; $display("FAIL stall_release_pc: got %h, required 0005", pc); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid: got %b, required 0", instr_valid); end
      checks++; if (imem_addr !== 13'h0005) begin failures++; $display("FAIL stall_release_addr: got %h, required 0005", imem_addr); end
   endtask

   task automatic test_flush_req();
      // entering at REQ with pc=5
      auto_lb     = 1'b0;
      imem_ready  = 1'b0;
      flush       = 1'b1;
      pc_loopback = 13'h0100;
      tick();
      flush = 1'b0;
      checks++; if (dbg_state !== DISCARD) begin failures++; $display("FAIL flreq_state: got %0d, required %0d", dbg_state, DISCARD); end
      checks++; if (pc !== 13'h0100) begin failures++; $display("FAIL flreq_pc: got %h, required 0100", pc); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_addr !== 13'h0005) begin failures++; $display("FAIL flreq_addr_hold: got %h, required 0005", imem_addr); end
         checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL flreq_req: got %b, required 1", imem_req); end
         checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flreq_valid: got %b, required 0", instr_valid); end
         tick();
      end
      imem_ready = 1'b1;
      tick();
      checks++; if (dbg_state !== REQ) begin failures++; $display("FAIL flreq_back_state: got %0d, required %0d", dbg_state, REQ); end
      checks++; if (imem_addr !== 13'h0100) begin failures++; $display("FAIL flreq_new_addr: got %h, required 0100", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flreq_dropped: got %b, required 0", instr_valid); end
      exp_q.push_back({13'h0100, word_of(13'h0100)});
      auto_lb     = 1'b1;
      pc_loopback = 13'h0101;
      tick();
      tick();
   endtask

   task automatic test_flush_hold();
      // entering at REQ with pc=0101
      exp_q.push_back({13'h0101, word_of(13'h0101)});
      tick();
      auto_lb     = 1'b0;
      stall       = 1'b1;
      flush       = 1'b1;
      imem_ready  = 1'b0;
      pc_loopback = 13'h0040;
      tick();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flhold_valid: got %b, required 0", instr_valid); end
      checks++; if (pc !== 13'h0040) begin failures++; $display("FAIL flhold_pc: got %h, required 0040", pc); end
      checks++; if (imem_addr !== 13'h0040) begin failures++; $display("FAIL flhold_addr: got %h, required 0040", imem_addr); end
      checks++; if (dbg_state !== REQ) begin failures++; $display("FAIL flhold_state: got %0d, required %0d", dbg_state, REQ); end
      // flush coinciding with a memory response in REQ
      stall       = 1'b0;
      imem_ready  = 1'b1;
      pc_loopback = 13'h0080;
      tick();
      flush = 1'b0;
      checks++; if (dbg_state !== REQ) begin failures++; $display("FAIL flrdy_state: got %0d, required %0d", dbg_state, REQ); end
      checks++; if (pc !== 13'h0080) begin failures++; $display("FAIL flrdy_pc: got %h, required 0080", pc); end
      checks++; if (imem_addr !== 13'h0080) begin failures++; $display("FAIL flrdy_addr: got %h, required 0080", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flrdy_valid: got %b, required 0", instr_valid); end
   endtask

   task automatic test_wrap();
      // entering at REQ with pc=0080, imem_ready=1
      flush       = 1'b1;
      pc_loopback = 13'h1FFF;
      tick();
      flush = 1'b0;
      checks++; if (pc !== 13'h1FFF) begin failures++; $display("FAIL wrap_pc: got %h, required 1fff", pc); end
      checks++; if (pc_plus1 !== 13'h0000) begin failures++; $display("FAIL wrap_plus1: got %h, required 0000", pc_plus1); end
      exp_q.push_back({13'h1FFF, word_of(13'h1FFF)});
      auto_lb     = 1'b1;
      pc_loopback = 13'h0000;
      tick();
      tick();
      checks++; if (pc !== 13'h0000) begin failures++; $display("FAIL wrap_next_pc: got %h, required 0000", pc); end
      checks++; if (imem_addr !== 13'h0000) begin failures++; $display("FAIL wrap_next_addr: got %h, required 0000", imem_addr); end
   endtask

   task automatic test_reset_discard();
      // entering at REQ with pc=0
      auto_lb     = 1'b0;
      imem_ready  = 1'b0;
      flush       = 1'b1;
      pc_loopback = 13'h0200;
      tick();
      flush = 1'b0;
      checks++; if (dbg_state !== DISCARD) begin failures++; $display("FAIL rdis_pre_state: got %0d, required %0d", dbg_state, DISCARD); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 13'h0000) begin failures++; $display("FAIL rdis_pc: got %h, required 0000", pc); end
      checks++; if (imem_addr !== 13'h0000) begin failures++; $display("FAIL rdis_addr: got %h, required 0000", imem_addr); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdis_req: got %b, required 0", imem_req); end
      checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL rdis_instr: got %h, required 0000", instr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdis_valid: got %b, required 0", instr_valid); end
      checks++; if (dbg_state !== BOOT) begin failures++; $display("FAIL rdis_state: got %0d, required %0d", dbg_state, BOOT); end
      // a late memory response during and after reset must be ignored
      imem_ready = 1'b1;
      tick();
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdis_held_req: got %b, required 0", imem_req); end
      rst_n = 1'b1;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdis_boot_valid: got %b, required 0", instr_valid); end
      tick();
      checks++; if (dbg_state !== REQ) begin failures++; $display("FAIL rdis_restart_state: got %0d, required %0d", dbg_state, REQ); end
      checks++; if (imem_addr !== 13'h0000) begin failures++; $display("FAIL rdis_restart_addr: got %h, required 0000", imem_addr); end
      exp_q.push_back({13'h0000, word_of(13'h0000)});
      stall = 1'b1;
      tick();
      checks++; if (instr !== word_of(13'h0000)) begin failures++; $display("FAIL rdis_restart_instr: got %h, required %h", instr, word_of(13'h0000)); end
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      stall       = 1'b0;
      imem_ready  = 1'b0;
      imem_rdata  = '0;
      pc_loopback = '0;

      test_reset();
      test_sequential();
      test_stall();
      test_flush_req();
      test_flush_hold();
      test_wrap();
      test_reset_discard();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending deliveries, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer; the stage directly downstream of the PC-loopback select mux.
- Holds the architectural PC and registers the selected next-PC (pc_loopback) when the current instruction retires.
- Drives a ready-based request to instruction memory and presents one registered instruction to decode with a valid/stall handshake.
- Exports pc_plus1 upstream so the jump-mux chain can select sequential flow.

Parameters:
PC_W, 13, program counter / instruction address width
INSTR_W, 16, instruction word width
RESET_PC, 13'h0000, PC value loaded on reset

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
pc_loopback  in  PC_W  selected next PC (sequential, jump target, or register value)
flush  in  1  redirect: abandon current fetch, restart at pc_loopback
stall  in  1  decode cannot accept instr this cycle
imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
imem_rdata  in  INSTR_W  fetched instruction word
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address, stable while imem_req && !imem_ready
pc  out  PC_W  address of instruction in instr / being fetched
pc_plus1  out  PC_W  pc + 1, combinational, feeds upstream mux
instr  out  INSTR_W  registered instruction to decode
instr_valid  out  1  instr holds a valid, unconsumed instruction

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr=0, instr_valid=0, state=BOOT.
- States: BOOT, REQ, HOLD, DISCARD. 2-bit encoding.
- Arithmetic: pc_plus1 = (pc + 1) mod 2^PC_W; 8191 wraps to 0. No other arithmetic.
- BOOT:
  - imem_req=0.
  - Next cycle go to REQ with imem_addr=pc.
  - flush in BOOT: pc<=pc_loopback, imem_addr<=pc_loopback, go to REQ.
- REQ:
  - imem_req=1.
  - imem_ready && !flush: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - flush && imem_ready: data dropped, pc<=imem_addr<=pc_loopback, stay in REQ.
  - flush && !imem_ready: pc<=pc_loopback, go to DISCARD. imem_addr keeps the old address.
- DISCARD:
  - imem_req=1 on the old address until imem_ready, then drop the data, set imem_addr<=pc, go to REQ.
  - A further flush in DISCARD updates pc only.
- HOLD:
  - imem_req=0, instr_valid=1.
  - Consume (instr_valid && !stall && !flush): pc<=pc_loopback, imem_addr<=pc_loopback, instr_valid<=0, go to REQ.
  - stall=1 holds instr, pc and state unchanged indefinitely.
  - flush (regardless of stall): instr_valid<=0, pc<=imem_addr<=pc_loopback, go to REQ.
- Priority: flush > consume > stall. instr_valid never asserts for data whose request preceded a flush.
- Latency and throughput:
  - imem_ready in the same cycle as imem_req gives instr_valid the next cycle.
  - Peak throughput is 1 instruction per 2 cycles (REQ, HOLD).
- pc_loopback is sampled only on consume or flush; other values are ignored.
- Reset mid-fetch: immediate return to BOOT and all outputs to reset values. An outstanding memory response after reset is ignored, because imem_req is low in BOOT.

Decomposition:
- Package mips16_pkg:
  - PC_W and INSTR_W constants.
  - RESET_PC default.
  - fetch_state_t enum (BOOT, REQ, HOLD, DISCARD).
- No sub-module. Single module: state register, pc/imem_addr/instr registers, next-state logic.

Test Plan:
- Reset then imem_ready tied 1, imem_rdata=16'hA001, stall=0, pc_loopback=pc_plus1 -> instr_valid on cycle 3 after rst_n rise; pc sequence 0,1,2 every 2 cycles; imem_addr tracks pc.
- stall=1 for 5 cycles in HOLD with instr=16'h1234 -> instr, pc and instr_valid constant; imem_req=0; consumes on first stall=0 cycle.
- REQ at pc=5 with imem_ready=0, flush=1, pc_loopback=13'h0100 -> DISCARD, imem_addr stays 5 until ready; returned word dropped (instr_valid stays 0); next REQ imem_addr=13'h0100.
- flush and stall both high in HOLD, pc_loopback=13'h0040 -> instr_valid=0 next cycle, pc=13'h0040, state REQ.
- pc=13'h1FFF -> pc_plus1=13'h0000; consume with pc_loopback=pc_plus1 -> next imem_addr=0.
- rst_n pulled low while in DISCARD -> all outputs return to reset values asynchronously; fetch restarts at RESET_PC after release.
